sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8: bit width of input and output pixels.
REQ-002 SHALL have parameter LINE_WIDTH, default 64: pixels per image line, minimum 3.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pixel_i, input, PIXEL_WIDTH: unsigned grayscale pixel, raster order.
REQ-006 SHALL have port pixel_valid_i, input, 1: pixel_i is valid.
REQ-007 SHALL have port sof_i, input, 1: start of frame, qualified by pixel_valid_i.
REQ-008 SHALL have port pixel_ready_o, output, 1: block accepts a pixel this cycle.
REQ-009 SHALL have port mode_i, input, 2: magnitude mode. 0 = |gx|+|gy|, 1 = max(|gx|,|gy|), 2 = |gx|, 3 = |gy|.
REQ-010 SHALL have port sobel_o, output, PIXEL_WIDTH: edge magnitude.
REQ-011 SHALL have port sobel_valid_o, output, 1: sobel_o is valid.
REQ-012 SHALL have port sobel_ready_i, input, 1: downstream accepts sobel_o.

Function
REQ-013 SHALL accept a pixel when pixel_valid_i && pixel_ready_o.
REQ-014 SHALL hold two line buffers of LINE_WIDTH entries and a 3x3 window register; each accepted pixel shifts into the window.
REQ-015 SHALL track column 0..LINE_WIDTH-1 (wraps to 0, row increments) and row saturating at 2.
REQ-016 SHALL mark a window valid only when row==2 and column>=2, so each frame produces (LINE_WIDTH-2) outputs per line from the third line on.
REQ-017 SHALL treat an accepted pixel with sof_i=1 as column 0, row 0, and SHALL drain outputs already in the pipeline unchanged.
REQ-018 SHALL compute gx = (p02-p00) + 2(p12-p10) + (p22-p20) and gy = (p20-p00) + 2(p21-p01) + (p22-p02) as signed values of PIXEL_WIDTH+3 bits, with p[row][col] and row 0 the oldest.
REQ-019 stage 1 SHALL register gx, gy and mode_i, sampled with the window's completing pixel.
REQ-020 stage 2 SHALL register the selected magnitude of absolute values, saturated to all-ones when it exceeds 2^PIXEL_WIDTH-1.
REQ-021 SHALL assert sobel_valid_o 2 cycles after the accepting edge of a window-completing pixel when there is no backpressure.
REQ-022 SHALL stall the whole pipeline while sobel_valid_o && !sobel_ready_i. pixel_ready_o = !(sobel_valid_o && !sobel_ready_i).
REQ-023 SHALL keep sobel_o stable while stalled, with no loss or duplication.
REQ-024 SHALL create a pipeline bubble for cycles without an accepted pixel and SHALL NOT emit output for it.

Reset
REQ-025 while nreset_i=0: sobel_valid_o=0, sobel_o=0, stage valids=0, column=0, row=0, window=0.
REQ-026 line-buffer contents SHALL NOT need reset; row gating masks them.
REQ-027 pixel_ready_o SHALL be 1 from the first cycle after reset release.
REQ-028 reset mid-frame SHALL discard all in-flight outputs; the next accepted pixel starts a new frame.

Configuration
REQ-029 with SOBEL_THRESHOLD_EN defined: SHALL add input threshold_i[PIXEL_WIDTH-1:0], sampled at stage 2, and sobel_o = all-ones if magnitude >= threshold_i, else 0.
REQ-030 without SOBEL_THRESHOLD_EN: threshold_i SHALL be absent and sobel_o = saturated magnitude.

Verification (PIXEL_WIDTH=8, LINE_WIDTH=4)
REQ-031 4 lines, all pixels 100, mode 0 -> exactly 4 outputs, all 0.
REQ-032 4 lines, columns {0,0,10,10}, mode 0 -> 4 outputs of 40; first sobel_valid_o 2 cycles after accepting line 2, column 2.
REQ-033 pixel = row+col, 4 lines, run with mode 0/1/2/3 -> outputs 16/8/8/8.
REQ-034 columns {0,0,255,255}, mode 0 -> gx=1020, so outputs saturate to 255.
REQ-035 sobel_ready_i low 5 cycles mid-stream -> sobel_o and sobel_valid_o held, pixel_ready_o=0, total output count unchanged.
REQ-036 sof_i at line 1, column 1 of a frame -> no output until line 2, column 2 of the new frame; with SOBEL_THRESHOLD_EN and threshold_i=40 on the REQ-032 image -> all outputs 255, and threshold_i=41 -> all outputs 0.

Source files
------------

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge-magnitude filter.
// Raster pixels in via valid/ready, edge magnitude out via valid/ready.
// Ports:
//   clk_i, nreset_i           clock, async active-low reset
//   pixel_i, pixel_valid_i    input pixel stream (raster order)
//   sof_i                     start of frame, qualified by pixel_valid_i
//   pixel_ready_o             input accepted this cycle when high
//   mode_i                    0:|gx|+|gy| 1:max 2:|gx| 3:|gy|
//   threshold_i               only with SOBEL_THRESHOLD_EN (binary output)
//   sobel_o, sobel_valid_o    output magnitude stream
//   sobel_ready_i             downstream ready
// Build option: define SOBEL_THRESHOLD_EN to add threshold_i.
module sobel_stream #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_WIDTH  = 64
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [PIXEL_WIDTH-1:0] pixel_i,
    input  logic                   pixel_valid_i,
    input  logic                   sof_i,
    output logic                   pixel_ready_o,
    input  logic [1:0]             mode_i,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIXEL_WIDTH-1:0] threshold_i,
`endif
    output logic [PIXEL_WIDTH-1:0] sobel_o,
    output logic                   sobel_valid_o,
    input  logic                   sobel_ready_i
);

    localparam int PW = PIXEL_WIDTH;
    localparam int GW = PIXEL_WIDTH + 3;
    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(LINE_WIDTH - 1);

    logic [CW-1:0]        r_col;
    logic [1:0]           r_row;
    logic [PW-1:0]        r_lb0 [LINE_WIDTH];
    logic [PW-1:0]        r_lb1 [LINE_WIDTH];
    logic [PW-1:0]        r_win [3][3];
    logic                 r_wv;
    logic [1:0]           r_wmode;
    logic                 r_s1_valid;
    logic signed [GW-1:0] r_gx;
    logic signed [GW-1:0] r_gy;
    logic [1:0]           r_s1_mode;
    logic                 r_out_valid;
    logic [PW-1:0]        r_out;

    logic                 w_stall;
    logic                 w_adv;
    logic                 w_accept;
    logic [CW-1:0]        w_col;
    logic [1:0]           w_row;
    logic [PW-1:0]        w_top;
    logic [PW-1:0]        w_mid;
    logic                 w_win_done;
    logic signed [GW-1:0] w_p [3][3];
    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic [GW-1:0]        w_ax;
    logic [GW-1:0]        w_ay;
    logic [GW-1:0]        w_mag;
    logic [PW-1:0]        w_res;

    // The whole pipeline freezes while the output is held.
    assign w_stall       = r_out_valid && !sobel_ready_i;
    assign w_adv         = !w_stall;
    assign pixel_ready_o = w_adv;
    assign w_accept      = pixel_valid_i && w_adv;

    // A start-of-frame pixel is forced to column 0, row 0.
    assign w_col = sof_i ? '0 : r_col;
    assign w_row = sof_i ? 2'd0 : r_row;

    // r_lb0 holds the previous line, r_lb1 the one before it.
    assign w_top = r_lb1[w_col];
    assign w_mid = r_lb0[w_col];

    assign w_win_done = w_accept && (w_row == 2'd2) && (w_col >= CW'(2));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_col <= '0;
            r_row <= 2'd0;
        end else if (w_accept) begin
            if (w_col == LAST) begin
                r_col <= '0;
                r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    // Line storage is masked by row gating, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lb0[w_col] <= pixel_i;
            r_lb1[w_col] <= w_mid;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_top;
            r_win[1][2] <= w_mid;
            r_win[2][2] <= pixel_i;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_wv    <= 1'b0;
            r_wmode <= 2'd0;
        end else if (w_adv) begin
            r_wv <= w_win_done;
            if (w_win_done)
                r_wmode <= mode_i;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_p[i][j] = $signed({3'b000, r_win[i][j]});
    end

    assign w_gx = (w_p[0][2] - w_p[0][0])
                + ((w_p[1][2] - w_p[1][0]) <<< 1)
                + (w_p[2][2] - w_p[2][0]);
    assign w_gy = (w_p[2][0] - w_p[0][0])
                + ((w_p[2][1] - w_p[0][1]) <<< 1)
                + (w_p[2][2] - w_p[0][2]);

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_s1_valid <= 1'b0;
            r_gx       <= '0;
            r_gy       <= '0;
            r_s1_mode  <= 2'd0;
        end else if (w_adv) begin
            r_s1_valid <= r_wv;
            if (r_wv) begin
                r_gx      <= w_gx;
                r_gy      <= w_gy;
                r_s1_mode <= r_wmode;
            end
        end
    end

    assign w_ax = r_gx[GW-1] ? (~r_gx + 1'b1) : r_gx;
    assign w_ay = r_gy[GW-1] ? (~r_gy + 1'b1) : r_gy;

    always_comb begin
        w_mag = '0;
        case (r_s1_mode)
            2'd0:    w_mag = w_ax + w_ay;
            2'd1:    w_mag = (w_ax > w_ay) ? w_ax : w_ay;
            2'd2:    w_mag = w_ax;
            default: w_mag = w_ay;
        endcase
    end

`ifdef SOBEL_THRESHOLD_EN
    assign w_res = (w_mag >= {3'b000, threshold_i}) ? '1 : '0;
`else
    assign w_res = (|w_mag[GW-1:PW]) ? '1 : w_mag[PW-1:0];
`endif

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid)
                r_out <= w_res;
        end
    end

    assign sobel_o       = r_out;
    assign sobel_valid_o = r_out_valid;

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: scoreboard bench for sobel_stream
// PIXEL_WIDTH=8, LINE_WIDTH=4, directed frames.
module tb_sobel_stream;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] pix = '0;
    logic       vld = 1'b0;
    logic       sof = 1'b0;
    logic       pix_rdy;
    logic [1:0] mode = 2'd0;
`ifdef SOBEL_THRESHOLD_EN
    logic [7:0] thr = '0;
`endif
    logic [7:0] sobel;
    logic       sval;
    logic       srdy = 1'b1;

    sobel_stream #(
        .PIXEL_WIDTH(8),
        .LINE_WIDTH (4)
    ) dut (
        .clk_i        (clk),
        .nreset_i     (nrst),
        .pixel_i      (pix),
        .pixel_valid_i(vld),
        .sof_i        (sof),
        .pixel_ready_o(pix_rdy),
        .mode_i       (mode),
`ifdef SOBEL_THRESHOLD_EN
        .threshold_i  (thr),
`endif
        .sobel_o      (sobel),
        .sobel_valid_o(sval),
        .sobel_ready_i(srdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int first_cyc = -1;
    int mark_cyc = 0;
    logic [7:0] exp_q [$];
    logic [7:0] img [16];
    logic [7:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (nrst && sval && srdy) begin
            out_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %0d want none", sobel);
            end else begin
                e = exp_q.pop_front();
                if (sobel !== e) begin
                    errors++;
                    $display("FAIL output got %0d want %0d", sobel, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input logic [7:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic fill_cols(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        for (int r = 0; r < 4; r++) begin
            img[r*4+0] = a;
            img[r*4+1] = b;
            img[r*4+2] = c;
            img[r*4+3] = d;
        end
    endtask

    task automatic fill_rc();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r*4+c] = 8'(r + c);
    endtask

    task automatic send_frame(input logic [1:0] m, input int n);
        logic acc;
        int   k;
        mode = m;
        for (int i = 0; i < n; i++) begin
            pix = img[i];
            vld = 1'b1;
            sof = (i == 0);
            acc = 1'b0;
            k = 0;
            while (!acc && k < 100) begin
                @(negedge clk);
                acc = pix_rdy;
                @(posedge clk);
                #1;
                k++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got 0 want 1");
            end
            if (i == 10) mark_cyc = cyc;
        end
        vld = 1'b0;
        sof = 1'b0;
    endtask

    task automatic drain(input string name, input int want_cnt);
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        repeat (5) @(posedge clk);
        #1;
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_count"}, out_cnt, want_cnt);
        out_cnt = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", sval, 0);
        check("reset_data", sobel, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", pix_rdy, 1);
        @(posedge clk);
        #1;

        // Flat image: no edges.
        fill_cols(100, 100, 100, 100);
        push(0, 4);
        send_frame(2'd0, 16);
        drain("flat", 4);

        // Vertical edge, latency from line 2 column 2.
        fill_cols(0, 0, 10, 10);
        first_cyc = -1;
        push(40, 4);
        send_frame(2'd0, 16);
        drain("edge", 4);
        check("latency", first_cyc - mark_cyc, 2);

        // Ramp under all four modes.
        fill_rc();
        push(16, 4);
        send_frame(2'd0, 16);
        drain("ramp_m0", 4);
        push(8, 4);
        send_frame(2'd1, 16);
        drain("ramp_m1", 4);
        // Back-to-back frames: tail of one drains into next.
        push(8, 8);
        send_frame(2'd2, 16);
        send_frame(2'd3, 16);
        drain("ramp_m2m3", 8);

        // Saturation.
        fill_cols(0, 0, 255, 255);
        push(255, 4);
        send_frame(2'd0, 16);
        drain("sat", 4);

        // Backpressure for 5 cycles on the first output.
        fill_cols(0, 0, 10, 10);
        push(40, 4);
        fork
            send_frame(2'd0, 16);
            begin : bp
                logic [7:0] held;
                int k = 0;
                while (!sval && k < 200) begin
                    @(posedge clk);
                    #2;
                    k++;
                end
                check("bp_seen", sval, 1);
                held = sobel;
                srdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid", sval, 1);
                    check("bp_data", sobel, held);
                    check("bp_ready", pix_rdy, 0);
                end
                check("bp_value", held, 40);
                @(posedge clk);
                #2;
                srdy = 1'b1;
            end
        join
        drain("bp", 4);

        // SOF at line 1 column 1 restarts the frame.
        fill_cols(200, 0, 200, 0);
        send_frame(2'd0, 5);
        fill_rc();
        push(16, 4);
        send_frame(2'd0, 16);
        drain("sof_mid", 4);

        // Reset with a window in flight discards it.
        fill_cols(0, 0, 10, 10);
        send_frame(2'd0, 11);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_valid", sval, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        push(40, 4);
        send_frame(2'd0, 16);
        drain("after_reset", 4);

`ifdef SOBEL_THRESHOLD_EN
        fill_cols(0, 0, 10, 10);
        thr = 8'd40;
        push(255, 4);
        send_frame(2'd0, 16);
        drain("thr40", 4);
        thr = 8'd41;
        push(0, 4);
        send_frame(2'd0, 16);
        drain("thr41", 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
